irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Interrupt/reset front end sitting directly upstream of the 65C02 core's IRQ_HANDLE/RESET states.
- Synchronizes the raw RES, NMI and IRQ pins, filters RES, and latches the NMI falling edge. Masks IRQ with the core's I flag.
- Presents one prioritized request (kind + vector address) to the core, which acknowledges at an instruction boundary.

Parameters:
SYNC_STAGES, 2, flip-flop depth of each pin synchronizer (legal range 2..4)
RES_HOLD_CYCLES, 2, consecutive synchronized-low cycles of RES required to register a reset

Ports:
clk  input  1  system clock (PHI_0 domain)
rst  input  1  synchronous reset, active-high
RES  input  1  external reset pin, active-low, asynchronous
NMI  input  1  non-maskable interrupt pin, active-low, asynchronous
IRQ  input  1  interrupt request pin, active-low, asynchronous
i_flag  input  1  core status I bit (1 = IRQ disabled)
req_ack  input  1  core takes the current request (one-cycle pulse)
req_valid  output  1  request pending
req_kind  output  2  int_kind_t: NONE, RESET, NMI, IRQ
req_vector  output  16  vector address for req_kind
core_hold  output  1  core must stay in RESET state (RES held low)

Behaviour:
- rst=1 at a clk edge: state=S_HOLD, all synchronizers preset to 1 (pins inactive), NMI latch=0, hold counter=0, core_hold=1, req_valid=0, req_kind=NONE, req_vector=16'hFFFC.
- Synchronized pins (res_s, nmi_s, irq_s) lag the pins by SYNC_STAGES cycles. All logic below uses synchronized values only.
- Hold counter: increments while res_s=0 and saturates at RES_HOLD_CYCLES. Clears when res_s=1. A glitch shorter than RES_HOLD_CYCLES is ignored.
- NMI latch: set on a 1->0 transition of nmi_s. Cleared by req_ack while req_kind=NMI. If set and clear coincide, set wins (a new edge is never lost). A level held low gives exactly one request.
- irq_active = (irq_s==0) && !i_flag. It is level-sensitive and not latched.
- States:
  - S_HOLD: core_hold=1, req_valid=0. Go to S_RESET when res_s=1 and the counter has saturated. rst exit is also gated on this condition.
  - S_RESET: req_valid=1, kind=RESET, vector FFFC. On req_ack go to S_IDLE.
  - S_IDLE: req_valid=1 whenever (NMI latch || irq_active). Priority is NMI > IRQ. Vectors: NMI=FFFA, IRQ=FFFE.
- From any state, saturated counter with res_s=0 -> S_HOLD, same cycle the count saturates. Reset mid-operation discards a pending request; the NMI latch is not cleared.
- kind/vector are combinational in S_IDLE and re-evaluate every cycle until ack. An NMI edge arriving while IRQ is pending upgrades the request to NMI (hijack). The core samples kind on the req_ack cycle.
- Either of these drops req_valid without an ack: IRQ deasserting, or i_flag rising before ack.
- req_ack while req_valid=0 is ignored.
- After an IRQ ack, a still-active IRQ re-requests on the next cycle. The core sets I during service, which masks it.

Optional Feature:
IRQ_CTRL_SO_EN:
- Defined: adds input SO (active-low pin) and output so_set (1 bit).
- SO is synchronized like the other pins. so_set pulses high for exactly one cycle on each 1->0 edge of the synchronized SO. so_set=0 in reset and in S_HOLD.
- Undefined: neither port exists.

Decomposition:
- Package proc_pkg:
  - int_kind_t (2-bit enum NONE=0, RESET=1, NMI=2, IRQ=3)
  - NMI_VECTOR=16'hFFFA, RESET_VECTOR=16'hFFFC, IRQ_VECTOR=16'hFFFE
  - irq_state_t
- Sub-module pin_sync: parameterized SYNC_STAGES shift register with a reset preset value. Instantiated once per pin.

Test Plan:
- rst for 3 cycles, RES=1 -> after release, req_valid=1, kind=RESET, vector=FFFC; ack -> req_valid=0, state S_IDLE.
- RES low for 1 cycle -> no core_hold. RES low for 4 cycles -> core_hold=1 within SYNC_STAGES+2 cycles. Release -> RESET request.
- NMI low held for 20 cycles -> exactly one NMI request (FFFA). Ack, no second request until NMI returns high and falls again.
- IRQ low, i_flag=0 -> request IRQ/FFFE. i_flag=1 before ack -> req_valid=0. i_flag=0 -> request returns.
- IRQ pending and unacked, then NMI edge -> kind switches to NMI/FFFA. Ack -> IRQ request re-presents next cycle (I still 0).
- With IRQ_CTRL_SO_EN: SO falls once and stays low 10 cycles -> so_set high for exactly 1 cycle, SYNC_STAGES+1 cycles after the pin edge.

Source files
------------

// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared interrupt kinds, vectors and controller states
package proc_pkg;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        RESET = 2'd1,
        NMI   = 2'd2,
        IRQ   = 2'd3
    } int_kind_t;

    localparam logic [15:0] NMI_VECTOR   = 16'hFFFA;
    localparam logic [15:0] RESET_VECTOR = 16'hFFFC;
    localparam logic [15:0] IRQ_VECTOR   = 16'hFFFE;

    typedef enum logic [1:0] {
        S_HOLD  = 2'd0,
        S_RESET = 2'd1,
        S_IDLE  = 2'd2
    } irq_state_t;

endpackage

// File: rtl/pin_sync.sv
// rtl/pin_sync.sv - multi-stage pin synchronizer with a reset preset value
module pin_sync #(
    parameter int   STAGES = 2,
    parameter logic PRESET = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= {STAGES{PRESET}};
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - RES/NMI/IRQ front end for the core; optional SO edge detect via IRQ_CTRL_SO_EN
module irq_ctrl
    import proc_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int RES_HOLD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RES,
    input  logic        NMI,
    input  logic        IRQ,
    input  logic        i_flag,
    input  logic        req_ack,
`ifdef IRQ_CTRL_SO_EN
    input  logic        SO,
    output logic        so_set,
`endif
    output logic        req_valid,
    output int_kind_t   req_kind,
    output logic [15:0] req_vector,
    output logic        core_hold
);

    localparam int CW = $clog2(RES_HOLD_CYCLES + 1);
    localparam logic [CW-1:0] CNT_SAT = CW'(RES_HOLD_CYCLES);

    logic res_s, nmi_s, irq_s;

    pin_sync #(.STAGES(SYNC_STAGES), .PRESET(1'b1)) u_sync_res (.clk(clk), .rst(rst), .d(RES), .q(res_s));
    pin_sync #(.STAGES(SYNC_STAGES), .PRESET(1'b1)) u_sync_nmi (.clk(clk), .rst(rst), .d(NMI), .q(nmi_s));
    pin_sync #(.STAGES(SYNC_STAGES), .PRESET(1'b1)) u_sync_irq (.clk(clk), .rst(rst), .d(IRQ), .q(irq_s));

    irq_state_t    state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          armed, armed_next;
    logic          hold_enter;
    logic          nmi_prev, nmi_lat, nmi_fall, nmi_clr;
    logic          irq_active;

    always_comb begin
        cnt_next = cnt;
        if (res_s) begin
            cnt_next = '0;
        end else if (cnt != CNT_SAT) begin
            cnt_next = cnt + 1'b1;
        end
    end

    // Hold is entered on the very edge the counter reaches saturation.
    assign hold_enter = !res_s && (cnt_next == CNT_SAT);
    assign nmi_fall   = nmi_prev && !nmi_s;
    assign nmi_clr    = req_ack && (state == S_IDLE) && nmi_lat;
    assign irq_active = !irq_s && !i_flag;

    always_comb begin
        state_next = state;
        unique case (state)
            S_HOLD:  if (res_s && armed) state_next = S_RESET;
            S_RESET: if (req_ack)        state_next = S_IDLE;
            S_IDLE:  state_next = S_IDLE;
            default: state_next = S_HOLD;
        endcase
        if (hold_enter) state_next = S_HOLD;
    end

    // rst counts as an already-registered reset, so the core leaves hold once RES reads high.
    always_comb begin
        armed_next = armed;
        if (hold_enter) begin
            armed_next = 1'b1;
        end else if (state == S_HOLD && state_next == S_RESET) begin
            armed_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_HOLD;
            cnt      <= '0;
            armed    <= 1'b1;
            nmi_prev <= 1'b1;
            nmi_lat  <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            armed    <= armed_next;
            nmi_prev <= nmi_s;
            nmi_lat  <= nmi_fall || (nmi_lat && !nmi_clr);
        end
    end

    always_comb begin
        core_hold  = 1'b0;
        req_valid  = 1'b0;
        req_kind   = proc_pkg::NONE;
        req_vector = RESET_VECTOR;
        unique case (state)
            S_HOLD: core_hold = 1'b1;
            S_RESET: begin
                req_valid = 1'b1;
                req_kind  = proc_pkg::RESET;
            end
            S_IDLE: begin
                if (nmi_lat) begin
                    req_valid  = 1'b1;
                    req_kind   = proc_pkg::NMI;
                    req_vector = NMI_VECTOR;
                end else if (irq_active) begin
                    req_valid  = 1'b1;
                    req_kind   = proc_pkg::IRQ;
                    req_vector = IRQ_VECTOR;
                end
            end
            default: core_hold = 1'b1;
        endcase
    end

`ifdef IRQ_CTRL_SO_EN
    logic so_s, so_prev;

    pin_sync #(.STAGES(SYNC_STAGES), .PRESET(1'b1)) u_sync_so (.clk(clk), .rst(rst), .d(SO), .q(so_s));

    always_ff @(posedge clk) begin
        if (rst) begin
            so_prev <= 1'b1;
            so_set  <= 1'b0;
        end else begin
            so_prev <= so_s;
            so_set  <= so_prev && !so_s && (state != S_HOLD);
        end
    end
`endif

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - directed self-checking bench for irq_ctrl
module tb_irq_ctrl;

    logic clk = 1'b0;
    logic rst, RES, NMI, IRQ, i_flag, req_ack;
    logic req_valid, core_hold;
    proc_pkg::int_kind_t req_kind;
    logic [15:0] req_vector;

    int n_checks = 0;
    int n_fails  = 0;
    int cnt;
    bit ok;

    irq_ctrl #(.SYNC_STAGES(2), .RES_HOLD_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .RES(RES), .NMI(NMI), .IRQ(IRQ),
        .i_flag(i_flag), .req_ack(req_ack),
        .req_valid(req_valid), .req_kind(req_kind),
        .req_vector(req_vector), .core_hold(core_hold)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ack();
        req_ack = 1'b1;
        tick();
        req_ack = 1'b0;
    endtask

    task automatic wait_valid(input int max, output bit got);
        got = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (req_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b1; RES = 1'b1; NMI = 1'b1; IRQ = 1'b1; i_flag = 1'b1; req_ack = 1'b0;
        tick(3);
        check("rst_core_hold", 16'(core_hold), 16'd1);
        check("rst_valid", 16'(req_valid), 16'd0);
        check("rst_kind", 16'(req_kind), 16'(proc_pkg::NONE));
        check("rst_vector", req_vector, 16'hFFFC);

        rst = 1'b0;
        tick();
        check("boot_valid", 16'(req_valid), 16'd1);
        check("boot_kind", 16'(req_kind), 16'(proc_pkg::RESET));
        check("boot_vector", req_vector, 16'hFFFC);
        check("boot_hold", 16'(core_hold), 16'd0);
        ack();
        check("boot_ack_valid", 16'(req_valid), 16'd0);
        check("boot_ack_kind", 16'(req_kind), 16'(proc_pkg::NONE));

        // One-cycle RES glitch must be filtered.
        RES = 1'b0;
        tick();
        RES = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (core_hold === 1'b1) cnt++;
        end
        check("glitch_no_hold", 16'(cnt), 16'd0);

        // RES low for 4 cycles: hold on the 4th edge, RESET request on the 7th.
        RES = 1'b0;
        tick(3);
        check("res_hold_early", 16'(core_hold), 16'd0);
        tick();
        check("res_hold_set", 16'(core_hold), 16'd1);
        check("res_hold_valid", 16'(req_valid), 16'd0);
        RES = 1'b1;
        tick(2);
        check("res_hold_keep", 16'(core_hold), 16'd1);
        tick();
        check("res_release_valid", 16'(req_valid), 16'd1);
        check("res_release_kind", 16'(req_kind), 16'(proc_pkg::RESET));
        check("res_release_hold", 16'(core_hold), 16'd0);
        ack();

        // NMI held low gives exactly one request.
        NMI = 1'b0;
        wait_valid(8, ok);
        check("nmi_seen", 16'(ok), 16'd1);
        check("nmi_kind", 16'(req_kind), 16'(proc_pkg::NMI));
        check("nmi_vector", req_vector, 16'hFFFA);
        ack();
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (req_valid === 1'b1) cnt++;
            tick();
        end
        check("nmi_level_once", 16'(cnt), 16'd0);
        NMI = 1'b1;
        tick(4);
        check("nmi_rise_quiet", 16'(req_valid), 16'd0);
        NMI = 1'b0;
        wait_valid(8, ok);
        check("nmi_second_edge", 16'(ok), 16'd1);
        check("nmi_second_kind", 16'(req_kind), 16'(proc_pkg::NMI));
        ack();
        check("nmi_second_ack", 16'(req_valid), 16'd0);

        // IRQ masking by i_flag.
        i_flag = 1'b0;
        IRQ = 1'b0;
        wait_valid(8, ok);
        check("irq_seen", 16'(ok), 16'd1);
        check("irq_kind", 16'(req_kind), 16'(proc_pkg::IRQ));
        check("irq_vector", req_vector, 16'hFFFE);
        i_flag = 1'b1;
        #1;
        check("irq_masked", 16'(req_valid), 16'd0);
        i_flag = 1'b0;
        #1;
        check("irq_unmasked", 16'(req_valid), 16'd1);
        check("irq_unmasked_kind", 16'(req_kind), 16'(proc_pkg::IRQ));

        // NMI edge hijacks the pending IRQ; IRQ re-presents right after the ack.
        NMI = 1'b1;
        tick(3);
        check("hijack_pre_kind", 16'(req_kind), 16'(proc_pkg::IRQ));
        NMI = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (req_kind === proc_pkg::NMI) begin
                ok = 1'b1;
                break;
            end
        end
        check("hijack_seen", 16'(ok), 16'd1);
        check("hijack_vector", req_vector, 16'hFFFA);
        check("hijack_valid", 16'(req_valid), 16'd1);
        ack();
        check("irq_represent_valid", 16'(req_valid), 16'd1);
        check("irq_represent_kind", 16'(req_kind), 16'(proc_pkg::IRQ));
        check("irq_represent_vector", req_vector, 16'hFFFE);
        ack();
        check("irq_reack_still", 16'(req_kind), 16'(proc_pkg::IRQ));

        // IRQ deasserting drops the request; a stray ack is ignored.
        IRQ = 1'b1;
        tick(3);
        check("irq_drop", 16'(req_valid), 16'd0);
        ack();
        check("stray_ack_valid", 16'(req_valid), 16'd0);
        check("stray_ack_hold", 16'(core_hold), 16'd0);
        IRQ = 1'b0;
        wait_valid(8, ok);
        check("irq_after_stray", 16'(ok), 16'd1);
        check("irq_after_stray_kind", 16'(req_kind), 16'(proc_pkg::IRQ));

        // Reset mid-operation discards IRQ but keeps a latched NMI.
        NMI = 1'b1;
        tick(3);
        NMI = 1'b0;
        RES = 1'b0;
        tick(4);
        check("mid_res_hold", 16'(core_hold), 16'd1);
        check("mid_res_valid", 16'(req_valid), 16'd0);
        RES = 1'b1;
        tick(3);
        check("mid_res_kind", 16'(req_kind), 16'(proc_pkg::RESET));
        ack();
        check("mid_res_nmi_kept", 16'(req_kind), 16'(proc_pkg::NMI));
        check("mid_res_nmi_vector", req_vector, 16'hFFFA);
        ack();
        check("mid_res_irq_after", 16'(req_kind), 16'(proc_pkg::IRQ));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
